rv_mem_arbiter: RTL
===================

Name: rv_mem_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF, read-only) and the load/store unit (DM, read/write).
- Accepts one upstream request at a time and issues it to memory.
- Routes the memory response back to the requester that issued it.
- Round-robin between the two requesters; one outstanding transaction; fetch flush suppresses a stale fetch response.

Parameters:
- Width, 32, address/data width; matches the core's Width (pc_t/addr_t/data_t).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req_valid  in  1  fetch request pending.
- if_req_addr  in  Width  fetch address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_flush  in  1  discard any in-flight or newly offered fetch.
- if_rsp_valid  out  1  fetch data valid, single-cycle pulse.
- if_rsp_data  out  Width  fetched word.
- dm_req_valid  in  1  data request pending.
- dm_req_addr  in  Width  data address.
- dm_req_we  in  1  1 = store, 0 = load.
- dm_req_be  in  Width/8  byte enables.
- dm_req_wdata  in  Width  store data.
- dm_req_ready  out  1  data request accepted this cycle.
- dm_rsp_valid  out  1  load data / store ack, single-cycle pulse.
- dm_rsp_data  out  Width  load data; don't-care for stores.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  Width  latched address.
- mem_req_we  out  1  latched write enable; 0 for fetch.
- mem_req_be  out  Width/8  latched byte enables; all ones for fetch.
- mem_req_wdata  out  Width  latched store data; 0 for fetch.
- mem_rsp_valid  in  1  memory response.
- mem_rsp_rdata  in  Width  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, owner=DM, prio=DM, drop=0, mem_req_* registers=0. All outputs 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, winner selection (combinational):
  - Candidates: dm_req_valid; if_req_valid && !if_flush.
  - Only one candidate: it wins.
  - Both: prio wins.
- IDLE, accept: winner's *_req_ready=1 in the same cycle. Latch addr/we/be/wdata (IF: we=0, be=all ones, wdata=0) and owner. Set prio to the loser. Go to ISSUE. No candidate: stay in IDLE, both readys 0.
- *_req_ready is 0 in ISSUE and WAIT.
- ISSUE: mem_req_valid=1. Fields are stable until handshake. On mem_req_ready go to WAIT.
- WAIT: on mem_rsp_valid go to IDLE. Same cycle, combinational route:
  - owner=DM: dm_rsp_valid=1.
  - owner=IF and drop=0: if_rsp_valid=1.
  - *_rsp_data = mem_rsp_rdata.
- Latency:
  - Accept at cycle N; mem_req_valid high from N+1.
  - Response is combinational with mem_rsp_valid.
  - Next accept is no earlier than the cycle after the response.
  - Minimum 3 cycles per transaction.
- Flush:
  - if_flush with owner=IF in ISSUE or WAIT sets drop=1. The memory transaction still completes and is not aborted.
  - The response is swallowed: if_rsp_valid stays 0.
  - drop clears on entering IDLE.
  - if_flush in the same cycle as the response also suppresses it.
  - if_flush with owner=DM has no effect on the DM transaction.
- Memory contract: mem_rsp_valid arrives no earlier than the cycle after the mem_req handshake. mem_rsp_valid in IDLE or ISSUE is ignored and produces no upstream pulse.
- Upstream contract: a requester holds valid and fields stable until ready. The arbiter never drops an accepted request.
- Reset mid-transaction: immediately returns to IDLE with outputs 0. Any later memory response is ignored under the rule above.

Test Plan:
- Single load: dm_req addr=0x100, we=0. Accepted in cycle 0. mem_req_valid cycle 1, ready cycle 1. rsp cycle 3, rdata=0xDEADBEEF → dm_rsp_valid pulse, data 0xDEADBEEF; if_rsp_valid=0.
- Contention: IF and DM both valid continuously from reset. Grant order DM, IF, DM, IF (prio toggles); each mem_req_addr matches the owner's address.
- Backpressure: mem_req_ready low 4 cycles during a store, addr=0x20, be=0x3, wdata=0x1234 → mem_req fields stable all 5 cycles; no upstream ready asserted; single dm_rsp_valid after the response.
- Flush in flight: fetch 0x40 accepted; if_flush pulsed in WAIT; response arrives → if_rsp_valid stays 0. A following fetch of 0x80 returns normally.
- Flush at offer: if_req_valid and if_flush high in IDLE with dm idle → if_req_ready=0, state stays IDLE. A same-cycle dm_req is still accepted.
- Async reset asserted in WAIT → outputs 0 immediately. A late mem_rsp_valid after release produces no rsp pulse; busy=0.

Source files
------------

// File: rtl/rv_mem_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch (IF)
// and the load/store unit (DM). Round-robin grant, one outstanding transaction,
// and a flush mechanism that swallows a stale fetch response.
module rv_mem_arbiter #(
  parameter int unsigned Width = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req_valid,
  input  logic [Width-1:0]   if_req_addr,
  output logic               if_req_ready,
  input  logic               if_flush,
  output logic               if_rsp_valid,
  output logic [Width-1:0]   if_rsp_data,
  input  logic               dm_req_valid,
  input  logic [Width-1:0]   dm_req_addr,
  input  logic               dm_req_we,
  input  logic [Width/8-1:0] dm_req_be,
  input  logic [Width-1:0]   dm_req_wdata,
  output logic               dm_req_ready,
  output logic               dm_rsp_valid,
  output logic [Width-1:0]   dm_rsp_data,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [Width-1:0]   mem_req_addr,
  output logic               mem_req_we,
  output logic [Width/8-1:0] mem_req_be,
  output logic [Width-1:0]   mem_req_wdata,
  input  logic               mem_rsp_valid,
  input  logic [Width-1:0]   mem_rsp_rdata,
  output logic               busy
);

  localparam int unsigned BeW = Width / 8;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;  // 1 = IF, 0 = DM
  logic               prio_q, prio_d;    // 1 = IF wins a tie
  logic               drop_q, drop_d;    // swallow the pending fetch response
  logic [Width-1:0]   addr_q, addr_d;
  logic               we_q, we_d;
  logic [BeW-1:0]     be_q, be_d;
  logic [Width-1:0]   wdata_q, wdata_d;

  logic if_cand, dm_cand, accept, grant_if, grant_dm, rsp_fire;

  // Winner selection; a flushed fetch is never a candidate. Grants are masked
  // during reset so every output reads 0 while rst_n is low.
  always_comb begin
    if_cand  = if_req_valid && !if_flush;
    dm_cand  = dm_req_valid;
    accept   = (state_q == StIdle) && rst_n && (if_cand || dm_cand);
    grant_if = accept && if_cand && (!dm_cand || prio_q);
    grant_dm = accept && dm_cand && (!if_cand || !prio_q);
    rsp_fire = (state_q == StWait) && mem_rsp_valid;
  end

  // Next-state: FSM, ownership, round-robin priority, drop flag and latched fields.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (grant_if) begin
          owner_d = 1'b1;
          prio_d  = 1'b0;
          addr_d  = if_req_addr;
          we_d    = 1'b0;
          be_d    = {BeW{1'b1}};
          wdata_d = '0;
          state_d = StIssue;
        end else if (grant_dm) begin
          owner_d = 1'b0;
          prio_d  = 1'b1;
          addr_d  = dm_req_addr;
          we_d    = dm_req_we;
          be_d    = dm_req_be;
          wdata_d = dm_req_wdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (if_flush && owner_q) drop_d = 1'b1;
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (if_flush && owner_q) drop_d = 1'b1;
        // Returning to idle clears drop regardless of a same-cycle flush.
        if (mem_rsp_valid) begin
          state_d = StIdle;
          drop_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Outputs: handshakes, memory request fields and combinational response routing.
  always_comb begin
    if_req_ready  = grant_if;
    dm_req_ready  = grant_dm;
    mem_req_valid = (state_q == StIssue);
    mem_req_addr  = addr_q;
    mem_req_we    = we_q;
    mem_req_be    = be_q;
    mem_req_wdata = wdata_q;
    dm_rsp_valid  = rsp_fire && !owner_q;
    if_rsp_valid  = rsp_fire && owner_q && !drop_q && !if_flush;
    dm_rsp_data   = dm_rsp_valid ? mem_rsp_rdata : '0;
    if_rsp_data   = if_rsp_valid ? mem_rsp_rdata : '0;
    busy          = (state_q != StIdle);
  end

endmodule
